wdog_apb_sequencer: RTL and testbench
=====================================

Name: wdog_apb_sequencer

Overview:
- APB master that programs and services the cmsdk_apb_watchdog on behalf of system logic.
- Sequences the unlock, load and control register writes on a config request.
- Clears the watchdog interrupt (a "kick") on request or automatically, and reads WDOGVALUE on request.
- Sits between the PCLK-domain system controller and the watchdog's APB slave port; it is the only master on that port.

Parameters:
- UNLOCK_KEY, 32'h1ACCE551, value written to WDOGLOCK to enable register writes.
- AUTO_KICK, 1, when 1 a rising edge of WDOGINT in IDLE launches a kick sequence without kick_req.

Ports:
- PCLK  in  1  single clock; the watchdog's APB port and WDOGCLK run from the same source.
- PRESET  in  1  synchronous active-high reset.
- cfg_req  in  1  single-cycle pulse; start the config sequence.
- cfg_load  in  32  value for WDOGLOAD, sampled on cfg_req.
- cfg_inten  in  1  WDOGCONTROL[0] (INTEN), sampled on cfg_req.
- cfg_resen  in  1  WDOGCONTROL[1] (RESEN), sampled on cfg_req.
- kick_req  in  1  single-cycle pulse; start the kick sequence.
- rd_req  in  1  single-cycle pulse; read WDOGVALUE.
- WDOGINT  in  1  watchdog interrupt.
- PRDATA  in  32  APB read data.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  10  word address [11:2].
- PWDATA  out  32  APB write data.
- busy  out  1  a sequence is in progress.
- done  out  1  one-cycle pulse in the cycle after the last access phase of any sequence.
- rd_value  out  32  last WDOGVALUE read; updated in the cycle done pulses for a read.
- pend_drop  out  1  one-cycle pulse when a request arrives while the same request type is already pending.

Behaviour:
- Reset values: every output is 0, FSM is IDLE, all pending flags are cleared. Reset applies at any point, including mid-access; PSEL/PENABLE drop on the next edge.
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - IDLE -> SETUP when any request is pending.
  - SETUP -> ACCESS always.
  - ACCESS -> SETUP if more ops remain, else -> DONE.
  - DONE -> IDLE.
- Bus timing: no PREADY; every access is exactly two cycles.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
  - PADDR, PWRITE and PWDATA are registered and held stable across both phases.
  - In IDLE and DONE, PSEL=PENABLE=PWRITE=0; PADDR and PWDATA hold their last values.
- Op lists (4-bit step counter; word addresses in parentheses):
  - Config: W LOCK(0x300)=UNLOCK_KEY; W LOAD(0x0)=cfg_load; W CONTROL(0x2)={30'b0,cfg_resen,cfg_inten}.
  - Kick: W LOCK=UNLOCK_KEY; W INTCLR(0x3)=1.
  - Read: R VALUE(0x1). PRDATA is captured on the ACCESS cycle.
- Request handling:
  - Each request type sets a pending flag; the flag clears when that sequence enters SETUP for its first op.
  - Requests are always latched, including while busy.
  - A request whose pending flag is already set asserts pend_drop and is otherwise ignored. cfg_load, cfg_inten and cfg_resen are not re-sampled for a dropped config request.
- Arbitration: evaluated only in IDLE; priority is config > kick > read. A running sequence is never preempted.
- Auto-kick (AUTO_KICK=1):
  - WDOGINT is registered and its 0->1 edge sets the kick pending flag.
  - A level that stays high does not re-trigger; a new rising edge after INTCLR does.
- Latency:
  - Request to first SETUP is 2 cycles (latch, then IDLE->SETUP).
  - Config is 6 bus cycles, kick 4, read 2; done follows in the next cycle.
- busy is 1 from the first SETUP through DONE.
- Simultaneous requests: all are latched in the same cycle and served back-to-back in priority order, each ending with its own DONE cycle.

Optional Feature:
- Macro: WDOG_SEQ_RELOCK_EN.
- Defined: config and kick sequences append W LOCK(0x300)=32'h0, which re-locks the watchdog. Config becomes 8 bus cycles and kick 6.
- Undefined: no relock write; the watchdog stays unlocked after the first sequence.

Decomposition:
- Package wdog_seq_pkg holds:
  - register word-address constants (LOAD, VALUE, CONTROL, INTCLR, RIS, MIS, LOCK);
  - UNLOCK_KEY default;
  - FSM state enum;
  - op struct {write, addr[9:0], data[31:0]};
  - sequence-type enum {SEQ_CFG, SEQ_KICK, SEQ_RD}.
- One sub-module, wdog_seq_oprom: combinational (sequence type, step, captured config) -> op struct plus a last flag; it honours WDOG_SEQ_RELOCK_EN.
- The top level holds the FSM, the pending flags and the APB output registers.

Test Plan:
- Config: after reset, pulse cfg_req with cfg_load=50, inten=1, resen=1 -> writes 0x300=0x1ACCE551, 0x0=50, 0x2=3 with correct SETUP/ACCESS timing; done pulses 1 cycle later; watchdog reload visible.
- Auto-kick: enable WDOGCLKEN; watchdog counts to 0 and WDOGINT rises -> kick writes 0x300=key, 0x3=1; WDOGINT falls; WDOGRES never asserts.
- Simultaneous requests: cfg_req, kick_req and rd_req in the same cycle -> sequences run in order config, kick, read; three done pulses; rd_value equals the watchdog's WDOGVALUE at sample time.
- Dropped request: second kick_req while a kick is pending -> pend_drop=1 for one cycle; exactly one kick sequence runs.
- Mid-sequence reset: assert PRESET during the LOAD write's ACCESS cycle -> next cycle PSEL=0, busy=0, no pending flags; a fresh cfg_req completes normally.
- Relock: with WDOG_SEQ_RELOCK_EN defined, config ends with 0x300=0; an external direct LOAD write afterwards is ignored by the watchdog.

Source files
------------

// File: rtl/wdog_seq_pkg.sv
// wdog_seq_pkg: shared constants and types for the watchdog APB sequencer.
package wdog_seq_pkg;
  localparam logic [9:0] ADDR_LOAD    = 10'h000;
  localparam logic [9:0] ADDR_VALUE   = 10'h001;
  localparam logic [9:0] ADDR_CONTROL = 10'h002;
  localparam logic [9:0] ADDR_INTCLR  = 10'h003;
  localparam logic [9:0] ADDR_RIS     = 10'h004;
  localparam logic [9:0] ADDR_MIS     = 10'h005;
  localparam logic [9:0] ADDR_LOCK    = 10'h300;
  localparam logic [31:0] DEF_UNLOCK_KEY = 32'h1ACCE551;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;
  typedef enum logic [1:0] {SEQ_CFG, SEQ_KICK, SEQ_RD} seq_e;
  typedef struct packed {
    logic        write;
    logic [9:0]  addr;
    logic [31:0] data;
  } op_t;
endpackage

// File: rtl/wdog_seq_oprom.sv
// wdog_seq_oprom: maps (sequence, step) to the APB op and a last-op flag.
// WDOG_SEQ_RELOCK_EN appends a relock write to the config and kick sequences.
module wdog_seq_oprom
  import wdog_seq_pkg::*;
#(
  parameter logic [31:0] UNLOCK_KEY = DEF_UNLOCK_KEY
) (
  input  seq_e        seq,
  input  logic [3:0]  step,
  input  logic [31:0] load,
  input  logic [1:0]  ctrl,
  output op_t         op,
  output logic        last
);
`ifdef WDOG_SEQ_RELOCK_EN
  localparam logic [3:0] LAST_CFG  = 4'd3;
  localparam logic [3:0] LAST_KICK = 4'd2;
`else
  localparam logic [3:0] LAST_CFG  = 4'd2;
  localparam logic [3:0] LAST_KICK = 4'd1;
`endif
  localparam op_t UNLOCK_OP = op_t'{1'b1, ADDR_LOCK, UNLOCK_KEY};
  localparam op_t RELOCK_OP = op_t'{1'b1, ADDR_LOCK, 32'h0};
  localparam op_t INTCLR_OP = op_t'{1'b1, ADDR_INTCLR, 32'h1};
  localparam op_t READ_OP   = op_t'{1'b0, ADDR_VALUE, 32'h0};
  always_comb begin
    op   = UNLOCK_OP;
    last = 1'b0;
    case (seq)
      SEQ_CFG: begin
        op   = step == 4'd1 ? op_t'{1'b1, ADDR_LOAD, load}
             : step == 4'd2 ? op_t'{1'b1, ADDR_CONTROL, {30'b0, ctrl}}
             : step == 4'd3 ? RELOCK_OP : UNLOCK_OP;
        last = step == LAST_CFG;
      end
      SEQ_KICK: begin
        op   = step == 4'd1 ? INTCLR_OP : step == 4'd2 ? RELOCK_OP : UNLOCK_OP;
        last = step == LAST_KICK;
      end
      default: begin
        op   = READ_OP;
        last = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/wdog_apb_sequencer.sv
// wdog_apb_sequencer: APB master that configures, kicks and reads the CMSDK watchdog.
// Optional relock write after config/kick is enabled by WDOG_SEQ_RELOCK_EN.
module wdog_apb_sequencer
  import wdog_seq_pkg::*;
#(
  parameter logic [31:0] UNLOCK_KEY = DEF_UNLOCK_KEY,
  parameter bit          AUTO_KICK  = 1'b1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cfg_req,
  input  logic [31:0] cfg_load,
  input  logic        cfg_inten,
  input  logic        cfg_resen,
  input  logic        kick_req,
  input  logic        rd_req,
  input  logic        WDOGINT,
  input  logic [31:0] PRDATA,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [9:0]  PADDR,
  output logic [31:0] PWDATA,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_value,
  output logic        pend_drop
);
  state_e      state_q, state_d;
  seq_e        seq_q, seq_d, op_seq;
  logic [3:0]  step_q, step_d, op_step;
  logic        cfg_pend_q, cfg_pend_d, kick_pend_q, kick_pend_d, rd_pend_q, rd_pend_d;
  logic [31:0] cfg_load_q, cfg_load_d, run_load_q, run_load_d;
  logic [1:0]  cfg_ctrl_q, cfg_ctrl_d, run_ctrl_q, run_ctrl_d;
  logic        wint_q, kick_in, op_last, last_q, last_d, pend_drop_q, pend_drop_d;
  logic        pwrite_q, pwrite_d;
  logic [9:0]  paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d, rd_value_q, rd_value_d;
  op_t         op;
  assign kick_in = kick_req || (AUTO_KICK && WDOGINT && !wint_q);
  assign op_seq  = state_q == IDLE ? (cfg_pend_q ? SEQ_CFG : kick_pend_q ? SEQ_KICK : SEQ_RD) : seq_q;
  assign op_step = state_q == IDLE ? 4'd0 : step_q + 4'd1;
  // The running config uses its own copy so a new request cannot disturb it mid-sequence.
  wdog_seq_oprom #(.UNLOCK_KEY(UNLOCK_KEY)) u_oprom (
    .seq  (op_seq),
    .step (op_step),
    .load (run_load_q),
    .ctrl (run_ctrl_q),
    .op   (op),
    .last (op_last)
  );
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    step_d      = step_q;
    last_d      = last_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rd_value_d  = rd_value_q;
    run_load_d  = run_load_q;
    run_ctrl_d  = run_ctrl_q;
    pend_drop_d = (cfg_req && cfg_pend_q) || (kick_in && kick_pend_q) || (rd_req && rd_pend_q);
    cfg_pend_d  = cfg_pend_q || cfg_req;
    kick_pend_d = kick_pend_q || kick_in;
    rd_pend_d   = rd_pend_q || rd_req;
    cfg_load_d  = cfg_req && !cfg_pend_q ? cfg_load : cfg_load_q;
    cfg_ctrl_d  = cfg_req && !cfg_pend_q ? {cfg_resen, cfg_inten} : cfg_ctrl_q;
    case (state_q)
      IDLE: begin
        if (cfg_pend_q || kick_pend_q || rd_pend_q) begin
          state_d     = SETUP;
          seq_d       = op_seq;
          step_d      = 4'd0;
          last_d      = op_last;
          pwrite_d    = op.write;
          paddr_d     = op.addr;
          pwdata_d    = op.data;
          cfg_pend_d  = op_seq == SEQ_CFG ? 1'b0 : cfg_pend_d;
          kick_pend_d = op_seq == SEQ_KICK ? 1'b0 : kick_pend_d;
          rd_pend_d   = op_seq == SEQ_RD ? 1'b0 : rd_pend_d;
          run_load_d  = op_seq == SEQ_CFG ? cfg_load_q : run_load_q;
          run_ctrl_d  = op_seq == SEQ_CFG ? cfg_ctrl_q : run_ctrl_q;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        rd_value_d = pwrite_q ? rd_value_q : PRDATA;
        if (last_q) begin
          state_d  = DONE;
          pwrite_d = 1'b0;
        end else begin
          state_d  = SETUP;
          step_d   = op_step;
          last_d   = op_last;
          pwrite_d = op.write;
          paddr_d  = op.addr;
          pwdata_d = op.data;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      seq_q       <= SEQ_CFG;
      step_q      <= 4'd0;
      last_q      <= 1'b0;
      cfg_pend_q  <= 1'b0;
      kick_pend_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      cfg_load_q  <= 32'h0;
      cfg_ctrl_q  <= 2'b0;
      run_load_q  <= 32'h0;
      run_ctrl_q  <= 2'b0;
      wint_q      <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 10'h0;
      pwdata_q    <= 32'h0;
      rd_value_q  <= 32'h0;
      pend_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      step_q      <= step_d;
      last_q      <= last_d;
      cfg_pend_q  <= cfg_pend_d;
      kick_pend_q <= kick_pend_d;
      rd_pend_q   <= rd_pend_d;
      cfg_load_q  <= cfg_load_d;
      cfg_ctrl_q  <= cfg_ctrl_d;
      run_load_q  <= run_load_d;
      run_ctrl_q  <= run_ctrl_d;
      wint_q      <= WDOGINT;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rd_value_q  <= rd_value_d;
      pend_drop_q <= pend_drop_d;
    end
  end
  assign PSEL      = state_q == SETUP || state_q == ACCESS;
  assign PENABLE   = state_q == ACCESS;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign rd_value  = rd_value_q;
  assign pend_drop = pend_drop_q;
endmodule

// File: tb/tb_wdog_apb_sequencer.sv
// tb_wdog_apb_sequencer: directed self-checking bench for the watchdog APB sequencer.
module tb_wdog_apb_sequencer;
`ifdef WDOG_SEQ_RELOCK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif
  localparam logic [31:0] KEY = 32'h1ACCE551;
  logic        PCLK = 1'b0, PRESET = 1'b1;
  logic        cfg_req = 1'b0, cfg_inten = 1'b0, cfg_resen = 1'b0;
  logic        kick_req = 1'b0, rd_req = 1'b0, WDOGINT = 1'b0;
  logic [31:0] cfg_load = 32'h0, PRDATA = 32'h0;
  logic        PSEL, PENABLE, PWRITE, busy, done, pend_drop;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA, rd_value;
  logic [46:0] obs;
  logic [42:0] acc_q[$];
  logic [42:0] exp_q[$];
  int          checks = 0, passed = 0, done_cnt = 0;

  wdog_apb_sequencer dut (
    .PCLK(PCLK), .PRESET(PRESET), .cfg_req(cfg_req), .cfg_load(cfg_load),
    .cfg_inten(cfg_inten), .cfg_resen(cfg_resen), .kick_req(kick_req), .rd_req(rd_req),
    .WDOGINT(WDOGINT), .PRDATA(PRDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .busy(busy), .done(done), .rd_value(rd_value),
    .pend_drop(pend_drop)
  );

  always #5 PCLK = ~PCLK;
  assign obs = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy, done};

  always @(negedge PCLK) begin
    if (PSEL && PENABLE) acc_q.push_back({PWRITE, PADDR, PWDATA});
    if (done) done_cnt++;
  end

  function automatic logic [46:0] bv(input logic s, input logic e, input logic w,
                                     input logic [9:0] a, input logic [31:0] d,
                                     input logic b, input logic dn);
    return {s, e, w, a, d, b, dn};
  endfunction

  function automatic void exp_cfg(input logic [31:0] ld, input logic [1:0] c);
    exp_q.push_back({1'b1, 10'h300, KEY});
    exp_q.push_back({1'b1, 10'h000, ld});
    exp_q.push_back({1'b1, 10'h002, {30'b0, c}});
    if (RELOCK) exp_q.push_back({1'b1, 10'h300, 32'h0});
  endfunction

  function automatic void exp_kick();
    exp_q.push_back({1'b1, 10'h300, KEY});
    exp_q.push_back({1'b1, 10'h003, 32'h1});
    if (RELOCK) exp_q.push_back({1'b1, 10'h300, 32'h0});
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== 47'h0) $display("FAIL reset_bus: got %h expected %h", obs, 47'h0);
    else passed++;
    checks++;
    if ({rd_value, pend_drop} !== 33'h0) $display("FAIL reset_regs: got %h expected 0", {rd_value, pend_drop});
    else passed++;
    PRESET = 1'b0;
  endtask

  task automatic test_config();
    logic w;
    logic [9:0] a;
    logic [31:0] d;
    exp_q.delete();
    exp_cfg(32'd50, 2'b11);
    cfg_load = 32'd50; cfg_inten = 1'b1; cfg_resen = 1'b1; cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    checks++;
    if (obs !== bv(0, 0, 0, 10'h0, 32'h0, 0, 0)) $display("FAIL cfg_latch: got %h expected idle", obs);
    else passed++;
    w = 1'b0; a = 10'h0; d = 32'h0;
    for (int k = 0; k < exp_q.size(); k++) begin
      tick();
      {w, a, d} = exp_q[k];
      checks++;
      if (obs !== bv(1, 0, w, a, d, 1, 0)) $display("FAIL cfg_setup%0d: got %h expected %h", k, obs, bv(1, 0, w, a, d, 1, 0));
      else passed++;
      tick();
      checks++;
      if (obs !== bv(1, 1, w, a, d, 1, 0)) $display("FAIL cfg_access%0d: got %h expected %h", k, obs, bv(1, 1, w, a, d, 1, 0));
      else passed++;
    end
    tick();
    checks++;
    if (obs !== bv(0, 0, 0, a, d, 1, 1)) $display("FAIL cfg_done: got %h expected %h", obs, bv(0, 0, 0, a, d, 1, 1));
    else passed++;
    tick();
    checks++;
    if (obs !== bv(0, 0, 0, a, d, 0, 0)) $display("FAIL cfg_idle: got %h expected %h", obs, bv(0, 0, 0, a, d, 0, 0));
    else passed++;
  endtask

  task automatic test_read();
    PRDATA = 32'h0000_1234;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    checks++;
    if (obs !== bv(1, 0, 0, 10'h001, 32'h0, 1, 0)) $display("FAIL rd_setup: got %h expected %h", obs, bv(1, 0, 0, 10'h001, 32'h0, 1, 0));
    else passed++;
    tick();
    checks++;
    if ({obs, rd_value} !== {bv(1, 1, 0, 10'h001, 32'h0, 1, 0), 32'h0}) $display("FAIL rd_access: got %h expected rd_value 0", {obs, rd_value});
    else passed++;
    tick();
    checks++;
    if ({done, rd_value} !== {1'b1, 32'h0000_1234}) $display("FAIL rd_done: got %h expected %h", {done, rd_value}, {1'b1, 32'h0000_1234});
    else passed++;
    tick();
  endtask

  task automatic test_kick();
    int base = acc_q.size(), d0 = done_cnt;
    logic [42:0] got;
    exp_q.delete();
    exp_kick();
    kick_req = 1'b1;
    tick();
    kick_req = 1'b0;
    for (int i = 0; i < 40 && done_cnt < d0 + 1; i++) tick();
    tick();
    checks++;
    if (done_cnt !== d0 + 1) $display("FAIL kick_done: got %0d expected %0d", done_cnt - d0, 1);
    else passed++;
    checks++;
    if (acc_q.size() - base !== exp_q.size()) $display("FAIL kick_count: got %0d expected %0d", acc_q.size() - base, exp_q.size());
    else passed++;
    foreach (exp_q[i]) begin
      got = base + i < acc_q.size() ? acc_q[base + i] : 'x;
      checks++;
      if (got !== exp_q[i]) $display("FAIL kick_op%0d: got %h expected %h", i, got, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_auto_kick();
    int base = acc_q.size(), d0 = done_cnt;
    logic [42:0] got;
    exp_q.delete();
    exp_kick();
    WDOGINT = 1'b1;
    for (int i = 0; i < 40 && done_cnt < d0 + 1; i++) tick();
    repeat (10) tick();
    checks++;
    if (done_cnt !== d0 + 1) $display("FAIL auto_done: got %0d expected 1", done_cnt - d0);
    else passed++;
    checks++;
    if (acc_q.size() - base !== exp_q.size()) $display("FAIL auto_level_hold: got %0d accesses expected %0d", acc_q.size() - base, exp_q.size());
    else passed++;
    foreach (exp_q[i]) begin
      got = base + i < acc_q.size() ? acc_q[base + i] : 'x;
      checks++;
      if (got !== exp_q[i]) $display("FAIL auto_op%0d: got %h expected %h", i, got, exp_q[i]);
      else passed++;
    end
    WDOGINT = 1'b0;
    repeat (3) tick();
    WDOGINT = 1'b1;
    for (int i = 0; i < 40 && done_cnt < d0 + 2; i++) tick();
    tick();
    WDOGINT = 1'b0;
    checks++;
    if (acc_q.size() - base !== 2 * exp_q.size()) $display("FAIL auto_second_edge: got %0d accesses expected %0d", acc_q.size() - base, 2 * exp_q.size());
    else passed++;
  endtask

  task automatic test_simultaneous();
    int base = acc_q.size(), d0 = done_cnt;
    logic [42:0] got;
    exp_q.delete();
    exp_cfg(32'h100, 2'b01);
    exp_kick();
    exp_q.push_back({1'b0, 10'h001, 32'h0});
    PRDATA = 32'hBEEF_0042;
    cfg_load = 32'h100; cfg_inten = 1'b1; cfg_resen = 1'b0;
    cfg_req = 1'b1; kick_req = 1'b1; rd_req = 1'b1;
    tick();
    cfg_req = 1'b0; kick_req = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < 80 && done_cnt < d0 + 3; i++) tick();
    repeat (5) tick();
    checks++;
    if (done_cnt !== d0 + 3) $display("FAIL sim_done_count: got %0d expected 3", done_cnt - d0);
    else passed++;
    checks++;
    if (acc_q.size() - base !== exp_q.size()) $display("FAIL sim_count: got %0d expected %0d", acc_q.size() - base, exp_q.size());
    else passed++;
    foreach (exp_q[i]) begin
      got = base + i < acc_q.size() ? acc_q[base + i] : 'x;
      checks++;
      if (got !== exp_q[i]) $display("FAIL sim_op%0d: got %h expected %h", i, got, exp_q[i]);
      else passed++;
    end
    checks++;
    if (rd_value !== 32'hBEEF_0042) $display("FAIL sim_rd_value: got %h expected %h", rd_value, 32'hBEEF_0042);
    else passed++;
  endtask

  task automatic test_drop_kick();
    int base = acc_q.size(), d0 = done_cnt;
    exp_q.delete();
    exp_kick();
    kick_req = 1'b1;
    tick();
    tick();
    kick_req = 1'b0;
    checks++;
    if (pend_drop !== 1'b1) $display("FAIL drop_pulse: got %b expected 1", pend_drop);
    else passed++;
    tick();
    checks++;
    if (pend_drop !== 1'b0) $display("FAIL drop_one_cycle: got %b expected 0", pend_drop);
    else passed++;
    for (int i = 0; i < 40 && done_cnt < d0 + 1; i++) tick();
    repeat (10) tick();
    checks++;
    if ({done_cnt - d0, acc_q.size() - base} !== {32'd1, exp_q.size()}) $display("FAIL drop_single_kick: got %0d done %0d accesses expected 1 done %0d accesses", done_cnt - d0, acc_q.size() - base, exp_q.size());
    else passed++;
  endtask

  task automatic test_drop_cfg();
    int base = acc_q.size(), d0 = done_cnt;
    logic [42:0] got;
    exp_q.delete();
    exp_cfg(32'd7, 2'b00);
    cfg_load = 32'd7; cfg_inten = 1'b0; cfg_resen = 1'b0; cfg_req = 1'b1;
    tick();
    cfg_load = 32'd99; cfg_inten = 1'b1; cfg_resen = 1'b1;
    tick();
    cfg_req = 1'b0;
    checks++;
    if (pend_drop !== 1'b1) $display("FAIL drop_cfg_pulse: got %b expected 1", pend_drop);
    else passed++;
    for (int i = 0; i < 40 && done_cnt < d0 + 1; i++) tick();
    repeat (5) tick();
    checks++;
    if (acc_q.size() - base !== exp_q.size()) $display("FAIL drop_cfg_count: got %0d expected %0d", acc_q.size() - base, exp_q.size());
    else passed++;
    foreach (exp_q[i]) begin
      got = base + i < acc_q.size() ? acc_q[base + i] : 'x;
      checks++;
      if (got !== exp_q[i]) $display("FAIL drop_cfg_op%0d: got %h expected %h", i, got, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    int base, d0;
    logic [42:0] got;
    cfg_load = 32'h40; cfg_inten = 1'b0; cfg_resen = 1'b1; cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    tick();
    kick_req = 1'b1;
    tick();
    kick_req = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== bv(1, 1, 1, 10'h000, 32'h40, 1, 0)) $display("FAIL mid_load_access: got %h expected %h", obs, bv(1, 1, 1, 10'h000, 32'h40, 1, 0));
    else passed++;
    PRESET = 1'b1;
    tick();
    checks++;
    if ({PSEL, PENABLE, busy} !== 3'b000) $display("FAIL mid_reset_drop: got %b expected 000", {PSEL, PENABLE, busy});
    else passed++;
    PRESET = 1'b0;
    base = acc_q.size();
    repeat (10) tick();
    checks++;
    if ({acc_q.size() - base, 31'b0, busy} !== 64'h0) $display("FAIL mid_reset_no_pending: got %0d accesses busy %b expected 0 0", acc_q.size() - base, busy);
    else passed++;
    exp_q.delete();
    exp_cfg(32'h40, 2'b10);
    base = acc_q.size();
    d0 = done_cnt;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    for (int i = 0; i < 40 && done_cnt < d0 + 1; i++) tick();
    repeat (3) tick();
    checks++;
    if (acc_q.size() - base !== exp_q.size()) $display("FAIL mid_fresh_count: got %0d expected %0d", acc_q.size() - base, exp_q.size());
    else passed++;
    foreach (exp_q[i]) begin
      got = base + i < acc_q.size() ? acc_q[base + i] : 'x;
      checks++;
      if (got !== exp_q[i]) $display("FAIL mid_fresh_op%0d: got %h expected %h", i, got, exp_q[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_read();
    test_kick();
    test_auto_kick();
    test_simultaneous();
    test_drop_kick();
    test_drop_cfg();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
